// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared constants and slot record for the forwarding/hazard unit.
package fwd_hazard_unit_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int FWD_REGFILE = 0;
    // Wide enough for any practical MAX_LAT; the slot zero-extends its latency input.
    localparam int SLOT_CNT_W  = 16;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [SLOT_CNT_W-1:0] cnt;
    } slot_t;
endpackage

// File: rtl/fwd_hazard_unit_mc_slot.sv
// mc_slot: one multi-cycle scoreboard entry counting down until its result is written.
module mc_slot
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int LAT_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_load,
    input  logic                         i_flush,
    input  logic [REG_ADDR_W-1:0]        i_rd,
    input  logic [LAT_W-1:0]             i_lat,
    input  logic [REG_ADDR_W*NUM_RS-1:0] i_rs_addr,
    output logic                         o_valid,
    output logic [NUM_RS-1:0]            o_match
);
    slot_t                 r_slot;
    logic [SLOT_CNT_W-1:0] w_lat;

    // A zero latency still occupies the slot for one cycle.
    assign w_lat = (i_lat == '0) ? SLOT_CNT_W'(1) : SLOT_CNT_W'(i_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_slot <= '0;
        else if (i_flush)
            r_slot <= '0;
        else if (i_load)
            r_slot <= slot_t'{valid: 1'b1, rd: i_rd, cnt: w_lat};
        else if (r_slot.valid)
            r_slot <= (r_slot.cnt == SLOT_CNT_W'(1)) ? '0 :
                      slot_t'{valid: 1'b1, rd: r_slot.rd, cnt: r_slot.cnt - SLOT_CNT_W'(1)};
    end

    assign o_valid = r_slot.valid;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_match
        assign o_match[g] = r_slot.valid && (r_slot.rd == i_rs_addr[g*REG_ADDR_W +: REG_ADDR_W]);
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select plus load-use and multi-cycle scoreboard stall.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC  = 3,
    parameter int NUM_RS   = 2,
    parameter int MC_SLOTS = 2,
    parameter int MAX_LAT  = 15,
    localparam int LAT_W   = $clog2(MAX_LAT + 1),
    localparam int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            i_src_regwrite,
    input  logic [REG_ADDR_W*NUM_SRC-1:0] i_src_rd,
    input  logic [NUM_SRC-1:0]            i_src_ready,
    input  logic [NUM_RS-1:0]             i_rs_used,
    input  logic [REG_ADDR_W*NUM_RS-1:0]  i_rs_addr,
    output logic [SEL_W*NUM_RS-1:0]       o_fwd_sel,
    input  logic                          i_mc_issue,
    input  logic [REG_ADDR_W-1:0]         i_mc_rd,
    input  logic [LAT_W-1:0]              i_mc_lat,
    output logic                          o_mc_full,
    input  logic                          i_flush,
    output logic                          o_stall,
    output logic [15:0]                   o_stall_cnt
);
    logic [NUM_RS-1:0]   w_rs_live;
    logic [NUM_RS-1:0]   w_load_use;
    logic [MC_SLOTS-1:0] w_valid;
    logic [MC_SLOTS-1:0] w_load;
    logic [NUM_RS-1:0]   w_match [MC_SLOTS];
    logic                w_sb_hit;
    logic                w_issue_ok;
    logic                w_found;
    logic [15:0]         r_stall_cnt;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_live
        assign w_rs_live[g] = i_rs_used[g] && (i_rs_addr[g*REG_ADDR_W +: REG_ADDR_W] != '0);
    end

    // Walk sources oldest to youngest so the youngest match wins.
    always_comb begin
        o_fwd_sel  = {NUM_RS{SEL_W'(FWD_REGFILE)}};
        w_load_use = '0;
        for (int j = 0; j < NUM_RS; j++)
            for (int k = NUM_SRC - 1; k >= 0; k--)
                if (w_rs_live[j] && i_src_regwrite[k] &&
                    i_src_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_rs_addr[j*REG_ADDR_W +: REG_ADDR_W]) begin
                    o_fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    w_load_use[j]               = !i_src_ready[k];
                end
    end

    always_comb begin
        w_sb_hit = 1'b0;
        for (int i = 0; i < MC_SLOTS; i++)
            w_sb_hit = w_sb_hit | (|(w_match[i] & w_rs_live));
    end

    assign o_stall    = (|w_load_use) || w_sb_hit;
    assign o_mc_full  = &w_valid;
    assign w_issue_ok = i_mc_issue && (i_mc_rd != '0) && !i_flush && !o_mc_full;

    // Only slots empty at cycle start are candidates, so an expiring slot is never reused.
    always_comb begin
        w_load  = '0;
        w_found = 1'b0;
        for (int i = 0; i < MC_SLOTS; i++)
            if (!w_valid[i] && !w_found) begin
                w_load[i] = w_issue_ok;
                w_found   = 1'b1;
            end
    end

    for (genvar g = 0; g < MC_SLOTS; g++) begin : g_slot
        mc_slot #(.NUM_RS(NUM_RS), .LAT_W(LAT_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_load[g]),
            .i_flush   (i_flush),
            .i_rd      (i_mc_rd),
            .i_lat     (i_mc_lat),
            .i_rs_addr (i_rs_addr),
            .o_valid   (w_valid[g]),
            .o_match   (w_match[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (o_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and randomized checks against a busy-until-cycle reference model.
module tb_fwd_hazard_unit;
    localparam int NS = 3;
    localparam int NR = 2;
    localparam int NM = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  src_regwrite;
    logic [14:0] src_rd;
    logic [2:0]  src_ready;
    logic [1:0]  rs_used;
    logic [9:0]  rs_addr;
    logic [3:0]  fwd_sel;
    logic        mc_issue;
    logic [4:0]  mc_rd;
    logic [3:0]  mc_lat;
    logic        mc_full;
    logic        flush;
    logic        stall;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int slot_end [NM];
    logic [4:0] slot_rd [NM];

    fwd_hazard_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_src_regwrite (src_regwrite),
        .i_src_rd       (src_rd),
        .i_src_ready    (src_ready),
        .i_rs_used      (rs_used),
        .i_rs_addr      (rs_addr),
        .o_fwd_sel      (fwd_sel),
        .i_mc_issue     (mc_issue),
        .i_mc_rd        (mc_rd),
        .i_mc_lat       (mc_lat),
        .o_mc_full      (mc_full),
        .i_flush        (flush),
        .o_stall        (stall),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a slot is busy while the cycle number is below its end cycle.
    function automatic bit slot_busy(int i);
        return slot_end[i] > cyc;
    endfunction

    function automatic int exp_sel(int j);
        logic [4:0] a = rs_addr[j*5 +: 5];
        if (!rs_used[j] || a == 0) return 0;
        for (int k = 0; k < NS; k++)
            if (src_regwrite[k] && src_rd[k*5 +: 5] == a) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        for (int j = 0; j < NR; j++) begin
            int s = exp_sel(j);
            if (s != 0 && !src_ready[s-1]) return 1;
            if (rs_used[j] && rs_addr[j*5 +: 5] != 0)
                for (int i = 0; i < NM; i++)
                    if (slot_busy(i) && slot_rd[i] == rs_addr[j*5 +: 5]) return 1;
        end
        return 0;
    endfunction

    function automatic bit exp_full();
        for (int i = 0; i < NM; i++)
            if (!slot_busy(i)) return 0;
        return 1;
    endfunction

    task automatic tick();
        bit st = exp_stall();
        bit fl = exp_full();
        if (rst_n) begin
            if (st && exp_cnt != 65535) exp_cnt++;
            if (flush) begin
                for (int i = 0; i < NM; i++) slot_end[i] = 0;
            end else if (mc_issue && mc_rd != 0 && !fl) begin
                for (int i = 0; i < NM; i++)
                    if (!slot_busy(i)) begin
                        slot_end[i] = cyc + 1 + ((mc_lat == 0) ? 1 : int'(mc_lat));
                        slot_rd[i]  = mc_rd;
                        break;
                    end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        src_regwrite = '0; src_rd = '0; src_ready = '1;
        rs_used = '0; rs_addr = '0;
        mc_issue = 0; mc_rd = '0; mc_lat = '0; flush = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        for (int i = 0; i < NM; i++) slot_end[i] = 0;
        exp_cnt = 0;
        src_regwrite = 3'b001; src_rd[4:0] = 5'd3; src_ready = 3'b110;
        rs_used = 2'b01; rs_addr[4:0] = 5'd3;
        mc_issue = 1; mc_rd = 5'd3; mc_lat = 4'd5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_comb_stall got %b exp 1", stall); end
        checks++; if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL reset_comb_sel got %0d exp 1", fwd_sel[1:0]); end
        tick(); tick();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        checks++; if (mc_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", mc_full); end
        set_idle();
        rs_used = 2'b01; rs_addr[4:0] = 5'd3;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_no_sb_stall got %b exp 0", stall); end
        @(negedge clk); rst_n = 1;
        tick();
    endtask

    task automatic test_fwd_basic();
        set_idle();
        src_regwrite = 3'b111; src_rd = {5'd5, 5'd5, 5'd5};
        rs_used = 2'b11; rs_addr = {5'd0, 5'd5};
        #1;
        checks++; if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL fwd_youngest got %0d exp 1", fwd_sel[1:0]); end
        checks++; if (fwd_sel[3:2] !== 2'd0) begin errors++; $display("FAIL fwd_r0 got %0d exp 0", fwd_sel[3:2]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_nostall got %b exp 0", stall); end
        src_regwrite = 3'b110; rs_addr = {5'd5, 5'd5}; rs_used = 2'b10;
        #1;
        checks++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_mid_unused got %h exp 8", fwd_sel); end
        src_rd = {5'd5, 5'd6, 5'd7}; src_regwrite = 3'b111; rs_used = 2'b11; rs_addr = {5'd7, 5'd5};
        #1;
        checks++; if (fwd_sel !== {2'd1, 2'd3}) begin errors++; $display("FAIL fwd_mixed got %h exp 7", fwd_sel); end
        tick();
    endtask

    task automatic test_load_use();
        int base;
        set_idle();
        src_regwrite = 3'b001; src_rd[4:0] = 5'd7; src_ready = 3'b110;
        rs_used = 2'b10; rs_addr[9:5] = 5'd7;
        #1;
        base = stall_cnt;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b exp 1", stall); end
        checks++; if (fwd_sel[3:2] !== 2'd1) begin errors++; $display("FAIL loaduse_sel got %0d exp 1", fwd_sel[3:2]); end
        tick(); tick(); tick();
        checks++; if (int'(stall_cnt) !== base + 3) begin errors++; $display("FAIL loaduse_cnt got %0d exp %0d", stall_cnt, base + 3); end
        checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL loaduse_model_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
        set_idle();
        tick();
    endtask

    task automatic test_mc_latency();
        set_idle();
        rs_used = 2'b01; rs_addr[4:0] = 5'd9;
        mc_issue = 1; mc_rd = 5'd9; mc_lat = 4'd4;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mclat_pre got %b exp 0", stall); end
        tick();
        mc_issue = 0;
        for (int n = 1; n <= 6; n++) begin
            #1;
            checks++;
            if (stall !== (n <= 4)) begin errors++; $display("FAIL mclat_cycle%0d got %b exp %b", n, stall, n <= 4); end
            tick();
        end
    endtask

    task automatic test_full_expiry();
        set_idle();
        flush = 1; tick(); flush = 0;
        mc_issue = 1; mc_rd = 5'd10; mc_lat = 4'd10; tick();
        mc_rd = 5'd11; tick();
        checks++; if (mc_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", mc_full); end
        mc_rd = 5'd12; tick();
        mc_issue = 0; rs_used = 2'b01; rs_addr[4:0] = 5'd12;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_ignored got %b exp 0", stall); end
        set_idle();
        flush = 1; tick(); flush = 0;
        mc_issue = 1; mc_rd = 5'd20; mc_lat = 4'd1; tick();
        mc_rd = 5'd13; mc_lat = 4'd3; tick();
        mc_rd = 5'd14; mc_lat = 4'd10; tick();
        mc_issue = 0;
        checks++; if (mc_full !== exp_full()) begin errors++; $display("FAIL expiry_full got %b exp %b", mc_full, exp_full()); end
        rs_used = 2'b11; rs_addr = {5'd14, 5'd13};
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL expiry_both got %b exp 1", stall); end
        rs_addr = {5'd20, 5'd20};
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL expiry_cleared got %b exp 0", stall); end
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        int base;
        set_idle();
        mc_issue = 1; mc_lat = 4'd12; mc_rd = 5'd17; tick();
        mc_rd = 5'd18; tick();
        mc_issue = 0;
        checks++; if (mc_full !== 1'b1) begin errors++; $display("FAIL flush_pre_full got %b exp 1", mc_full); end
        base = stall_cnt;
        flush = 1; mc_issue = 1; mc_rd = 5'd19; mc_lat = 4'd5;
        tick();
        set_idle();
        rs_used = 2'b11; rs_addr = {5'd18, 5'd19};
        #1;
        checks++; if (mc_full !== 1'b0) begin errors++; $display("FAIL flush_full got %b exp 0", mc_full); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
        checks++; if (int'(stall_cnt) !== base) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", stall_cnt, base); end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        set_idle();
        mc_issue = 1; mc_rd = 5'd21; mc_lat = 4'd15; tick();
        mc_issue = 0; rs_used = 2'b01; rs_addr[4:0] = 5'd21;
        tick(); tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", stall); end
        #2 rst_n = 0;
        for (int i = 0; i < NM; i++) slot_end[i] = 0;
        exp_cnt = 0;
        #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", stall_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", stall); end
        @(negedge clk); rst_n = 1;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b exp 0", stall); end
        checks++; if (mc_full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b exp 0", mc_full); end
        set_idle();
        mc_issue = 1; mc_rd = 5'd0; mc_lat = 4'd5;
        src_regwrite = 3'b111; src_rd = '0; src_ready = 3'b000;
        rs_used = 2'b11; rs_addr = '0;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got %b exp 0", stall); end
        checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL zero_reg_sel got %h exp 0", fwd_sel); end
        mc_issue = 0; rs_used = 2'b00; rs_addr = {5'd3, 5'd3};
        #1;
        checks++; if (mc_full !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL zero_rd_issue full %b stall %b exp 0 0", mc_full, stall); end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            src_regwrite = 3'($urandom);
            for (int k = 0; k < NS; k++) src_rd[k*5 +: 5] = 5'($urandom_range(0, 7));
            src_ready = 3'($urandom | $urandom);
            rs_used = 2'($urandom);
            for (int j = 0; j < NR; j++) rs_addr[j*5 +: 5] = 5'($urandom_range(0, 7));
            mc_issue = ($urandom_range(0, 2) == 0);
            mc_rd = 5'($urandom_range(0, 7));
            mc_lat = 4'($urandom_range(0, 6));
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (fwd_sel !== {2'(exp_sel(1)), 2'(exp_sel(0))}) begin
                errors++; $display("FAIL rand_sel cyc %0d got %h exp %0d/%0d", cyc, fwd_sel, exp_sel(1), exp_sel(0));
            end
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall cyc %0d got %b exp %b", cyc, stall, exp_stall()); end
            checks++; if (mc_full !== exp_full()) begin errors++; $display("FAIL rand_full cyc %0d got %b exp %b", cyc, mc_full, exp_full()); end
            checks++; if (stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", cyc, stall_cnt, exp_cnt); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_load_use();
        test_mc_latency();
        test_full_expiry();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of forwarding sources; index 0 is youngest (EX/MEM), then MEM/WB, then WB.
REQ-002 SHALL have parameter NUM_RS, default 2, number of consumer source-register ports.
REQ-003 SHALL have parameter MC_SLOTS, default 2, number of multi-cycle scoreboard slots.
REQ-004 SHALL have parameter MAX_LAT, default 15, maximum multi-cycle latency; LAT_W = clog2(MAX_LAT+1); SEL_W = clog2(NUM_SRC+1).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_regwrite  in  NUM_SRC  source k writes a register.
- src_rd  in  5*NUM_SRC  destination of source k.
- src_ready  in  NUM_SRC  source k's data is valid this cycle (0 = load not yet returned).
- rs_used  in  NUM_RS  consumer port j reads a register.
- rs_addr  in  5*NUM_RS  register read by port j.
- fwd_sel  out  SEL_W*NUM_RS  0 = register file; k+1 = source k.
- mc_issue  in  1  multi-cycle op issued this cycle.
- mc_rd  in  5  destination of issued op.
- mc_lat  in  LAT_W  cycles until result is written.
- mc_full  out  1  all slots valid.
- flush  in  1  pipeline flush.
- stall  out  1  hold consumer stage.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-006 fwd_sel[j] SHALL select the lowest-index k where src_regwrite[k], src_rd[k]!=0, and src_rd[k]==rs_addr[j]; else 0; combinational.
REQ-007 rs_used[j]=0 or rs_addr[j]==0 SHALL force fwd_sel[j]=0 and contribute no stall.
REQ-008 stall SHALL assert combinationally when, for any used port j, the selected source k has src_ready[k]=0 (load-use).
REQ-009 stall SHALL assert when any valid scoreboard slot's rd equals a used nonzero rs_addr[j], regardless of forwarding match.
REQ-010 Each slot SHALL hold valid, rd[4:0], cnt[LAT_W-1:0].
REQ-011 On mc_issue with mc_rd!=0 and at least one slot free at cycle start, the lowest-index free slot SHALL load valid=1, rd=mc_rd, cnt=max(mc_lat,1) at the next edge.
REQ-012 mc_issue with mc_rd==0, or while mc_full=1, SHALL be ignored (no slot change).
REQ-013 Each valid slot SHALL decrement cnt every cycle; when cnt==1 the slot SHALL clear at that edge (busy for exactly max(mc_lat,1) cycles after issue).
REQ-014 Expiry and issue in the same cycle SHALL both take effect; the expiring slot SHALL NOT be reused that cycle.
REQ-015 Two valid slots with equal rd SHALL be permitted; the stall lasts until both clear.
REQ-016 mc_full SHALL equal the AND of all slot valids (registered state, no combinational path from mc_issue).
REQ-017 flush SHALL clear all slots at the next edge and SHALL take priority over a simultaneous mc_issue.
REQ-018 stall_cnt SHALL increment on each edge where stall=1, saturate at 0xFFFF, and not be cleared by flush.

Reset
REQ-019 rst_n low SHALL asynchronously clear all slot valid/rd/cnt and stall_cnt; mc_full=0.
REQ-020 During reset, stall and fwd_sel SHALL follow their combinational inputs only (no scoreboard contribution).
REQ-021 Reset deassertion mid-operation SHALL leave the block empty; in-flight ops are lost.

Structure
REQ-022 A shared package SHALL hold REG_ADDR_W=5, the fwd_sel encoding constant FWD_REGFILE=0, and the slot record typedef.
REQ-023 One sub-module, mc_slot (single slot: valid/rd/countdown, load, flush, match output), SHALL be instantiated MC_SLOTS times.

Verification
REQ-024 src_rd={5,5,5} all regwrite, rs_addr[0]=5, all ready -> fwd_sel[0]=1, stall=0.
REQ-025 src0 regwrite rd=7 src_ready[0]=0, rs_addr[1]=7 used -> stall=1, fwd_sel[1]=1; stall_cnt +1 per cycle.
REQ-026 mc_issue rd=9 lat=4, rs_addr[0]=9 -> stall=1 exactly 4 cycles after the issue edge, then 0.
REQ-027 Fill both slots (lat=10), issue third -> ignored, mc_full=1; slot with lat=1 expires while issuing -> new op takes the next free slot, not the expiring one.
REQ-028 Slots busy, flush with mc_issue same cycle -> all slots empty next cycle, mc_full=0, stall_cnt unchanged.
REQ-029 rst_n pulsed low mid-countdown -> slots and stall_cnt 0 immediately, no stall from scoreboard afterwards; rd=0 issue and rs_addr=0 never stall.
